vga_timing_generator: RTL and testbench

- Generates the raster scan counts hCount/vCount and the hSync/vSync pulses that drive the VGA connector.
- Its hCount/vCount outputs feed the downstream pixel-coordinate stage, which derives xPixel/yPixel/pixelDrawing.
- Divides the system clock into a pixel-rate enable; all counting advances only on that enable.
- Default timing: 640x480@60 Hz from a 100 MHz clock (CLK_DIV=4 gives a 25 MHz pixel rate).

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_pixel_tick_gen.sv | 29 ++
 rtl/vga_timing_generator.sv | 87 ++++++++
 tb/tb_vga_timing_generator.sv | 114 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing defaults, count width and raster-limit helper
package vga_timing_pkg;
    localparam int COUNT_W = 12;
    localparam int HPIXEL  = 640;
    localparam int HFP     = 16;
    localparam int HSYNC   = 96;
    localparam int HBP     = 48;
    localparam int VPIXEL  = 480;
    localparam int VFP     = 10;
    localparam int VSYNC   = 2;
    localparam int VBP     = 33;

    // Total positions per line or lines per frame from the active/porch/sync widths
    function automatic int raster_limit(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_pixel_tick_gen.sv
// vga_pixel_tick_gen: divides clk by CLK_DIV into a one-clk pixel enable
//   clk       in  system clock
//   rst_n     in  asynchronous reset, active-low
//   tick_en   out combinational wrap of the divider; the edge it is high on registers pixelTick
//   pixelTick out registered one-clk pixel enable
module vga_pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_en,
    output logic pixelTick
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_count;

    assign tick_en = div_count == DW'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_count <= '0;
            pixelTick <= 1'b0;
        end else begin
            div_count <= tick_en ? '0 : div_count + 1'b1;
            pixelTick <= tick_en;
        end
    end
endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster counters, sync pulses and line/frame start pulses
//   clk        in  system clock
//   rst_n      in  asynchronous reset, active-low
//   hCount     out horizontal position 0..PIXEL_LIMIT-1
//   vCount     out vertical position 0..LINE_LIMIT-1
//   hSync      out horizontal sync, asserted level SYNC_ACTIVE
//   vSync      out vertical sync, asserted level SYNC_ACTIVE
//   pixelTick  out one-clk pixel enable
//   lineStart  out one-clk pulse when hCount wraps to 0
//   frameStart out one-clk pulse when (hCount,vCount) wraps to (0,0)
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   HPIXEL      = vga_timing_pkg::HPIXEL,
    parameter int   HFP         = vga_timing_pkg::HFP,
    parameter int   HSYNC       = vga_timing_pkg::HSYNC,
    parameter int   HBP         = vga_timing_pkg::HBP,
    parameter int   VPIXEL      = vga_timing_pkg::VPIXEL,
    parameter int   VFP         = vga_timing_pkg::VFP,
    parameter int   VSYNC       = vga_timing_pkg::VSYNC,
    parameter int   VBP         = vga_timing_pkg::VBP,
    parameter int   CLK_DIV     = 4,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               pixelTick,
    output logic               lineStart,
    output logic               frameStart
);
    localparam int PIXEL_LIMIT = raster_limit(HPIXEL, HFP, HSYNC, HBP);
    localparam int LINE_LIMIT  = raster_limit(VPIXEL, VFP, VSYNC, VBP);

    if (PIXEL_LIMIT > 4096 || LINE_LIMIT > 4096) begin : g_limit_check
        $error("vga_timing_generator: raster limits exceed 12-bit counters");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_generator: CLK_DIV must be at least 1");
    end

    logic               tick_en;
    logic               h_wrap;
    logic               v_wrap;
    logic [COUNT_W-1:0] h_next;
    logic [COUNT_W-1:0] v_next;
    logic               hs_on;
    logic               vs_on;

    vga_pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_en  (tick_en),
        .pixelTick(pixelTick)
    );

    // Syncs are decoded from the next-state counts so the registered syncs line up with the counts
    always_comb begin
        h_wrap = hCount == COUNT_W'(PIXEL_LIMIT - 1);
        v_wrap = vCount == COUNT_W'(LINE_LIMIT - 1);
        h_next = tick_en ? (h_wrap ? '0 : hCount + 1'b1) : hCount;
        v_next = (tick_en && h_wrap) ? (v_wrap ? '0 : vCount + 1'b1) : vCount;
        hs_on  = h_next >= COUNT_W'(HPIXEL + HFP) && h_next < COUNT_W'(HPIXEL + HFP + HSYNC);
        vs_on  = v_next >= COUNT_W'(VPIXEL + VFP) && v_next < COUNT_W'(VPIXEL + VFP + VSYNC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= ~SYNC_ACTIVE;
            vSync      <= ~SYNC_ACTIVE;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            hCount     <= h_next;
            vCount     <= v_next;
            hSync      <= hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSync      <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            lineStart  <= tick_en && h_wrap;
            frameStart <= tick_en && h_wrap && v_wrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: scoreboard bench for default, small-raster and CLK_DIV=1/active-high variants
module tb_vga_timing_generator;
    typedef logic [28:0] obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ha, va, hb, vb, hc, vc;
    logic hsa, vsa, pta, lsa, fsa;
    logic hsb, vsb, ptb, lsb, fsb;
    logic hsc, vsc, ptc, lsc, fsc;
    obs_t oa, ob, oc;
    assign oa = {ha, va, hsa, vsa, pta, lsa, fsa};
    assign ob = {hb, vb, hsb, vsb, ptb, lsb, fsb};
    assign oc = {hc, vc, hsc, vsc, ptc, lsc, fsc};

    vga_timing_generator u_a (
        .clk(clk), .rst_n(rst_n), .hCount(ha), .vCount(va), .hSync(hsa), .vSync(vsa),
        .pixelTick(pta), .lineStart(lsa), .frameStart(fsa)
    );

    vga_timing_generator #(
        .HPIXEL(8), .HFP(2), .HSYNC(3), .HBP(2), .VPIXEL(4), .VFP(1), .VSYNC(2), .VBP(1),
        .CLK_DIV(4), .SYNC_ACTIVE(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .hCount(hb), .vCount(vb), .hSync(hsb), .vSync(vsb),
        .pixelTick(ptb), .lineStart(lsb), .frameStart(fsb)
    );

    vga_timing_generator #(
        .HPIXEL(8), .HFP(2), .HSYNC(3), .HBP(2), .VPIXEL(4), .VFP(1), .VSYNC(2), .VBP(1),
        .CLK_DIV(1), .SYNC_ACTIVE(1'b1)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .hCount(hc), .vCount(vc), .hSync(hsc), .vSync(vsc),
        .pixelTick(ptc), .lineStart(lsc), .frameStart(fsc)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;
    obs_t q[$];

    // Expected outputs after k post-reset clocks, derived from the elapsed tick count
    function automatic obs_t model(input int kk, input int hp, input int hf, input int hs, input int hbp,
                                   input int vp, input int vf, input int vs, input int vbp,
                                   input int div, input logic sa);
        int pl, ll, n, h, v;
        logic t, ls, hsy, vsy;
        pl  = hp + hf + hs + hbp;
        ll  = vp + vf + vs + vbp;
        n   = kk / div;
        h   = n % pl;
        v   = (n / pl) % ll;
        t   = kk > 0 && kk % div == 0;
        ls  = t && h == 0;
        hsy = (h >= hp + hf && h < hp + hf + hs) ? sa : ~sa;
        vsy = (v >= vp + vf && v < vp + vf + vs) ? sa : ~sa;
        return {12'(h), 12'(v), hsy, vsy, t, ls, ls && v == 0};
    endfunction

    function automatic obs_t exp_a(input int kk);
        return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0);
    endfunction
    function automatic obs_t exp_b(input int kk);
        return model(kk, 8, 2, 3, 2, 4, 1, 2, 1, 4, 1'b0);
    endfunction
    function automatic obs_t exp_c(input int kk);
        return model(kk, 8, 2, 3, 2, 4, 1, 2, 1, 1, 1'b1);
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) k++;
        q.push_back(exp_a(k));
        q.push_back(exp_b(k));
        q.push_back(exp_c(k));
        #1;
        check("raster_a", oa, q.pop_front());
        check("raster_b", ob, q.pop_front());
        check("raster_c", oc, q.pop_front());
    endtask

    initial begin
        repeat (5) step();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        check("no_tick_before_4th", 29'(pta), 29'(0));
        step();
        check("first_tick_4th_clk", 29'(pta), 29'(1));
        check("first_tick_div1", 29'(ptc), 29'(1));
        repeat (7000) step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        k = 0;
        #1;
        check("async_reset_a", oa, exp_a(0));
        check("async_reset_b", ob, exp_b(0));
        check("async_reset_c", oc, exp_c(0));
        repeat (3) step();
        @(negedge clk) rst_n = 1'b1;
        repeat (2000) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
